mouse_pos_tracker: RTL and testbench
====================================

Name: mouse_pos_tracker

Overview:
- Consumes 3-byte PS/2 mouse packets from the PS/2 receiver (rd_vld/rd_data) and turns relative movement into absolute, clamped X/Y cursor coordinates plus button state.
- Runs in parallel with seg7_control, downstream of ps2_top; its outputs feed the display and LED logic.
- Two-stage pipeline: decode then accumulate/clamp. Malformed packets are dropped and counted.

Parameters:
- X_MAX, 639, largest legal X coordinate (minimum is 0).
- Y_MAX, 479, largest legal Y coordinate (minimum is 0).
- POS_W, 10, width of the position outputs; must satisfy 2^POS_W > max(X_MAX, Y_MAX).
- SPEED_SHIFT, 0, left-shift applied to each delta (sensitivity gain ×2^SPEED_SHIFT); range 0..3.
- INVERT_Y, 1, 1 = PS/2 +Y (up) decrements pos_y (screen coordinates); 0 = increments.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- rd_vld  in  1  one-cycle strobe: rd_data holds a complete packet.
- rd_data  in  24  [23:16] status byte, [15:8] X movement, [7:0] Y movement.
- recentre  in  1  one-cycle pulse: move the cursor to the centre.
- pos_x  out  POS_W  current X, 0..X_MAX.
- pos_y  out  POS_W  current Y, 0..Y_MAX.
- btn_l  out  1  left button (status bit0).
- btn_r  out  1  right button (status bit1).
- btn_m  out  1  middle button (status bit2).
- pos_vld  out  1  one-cycle pulse: pos/buttons were just updated.
- err_cnt  out  8  count of dropped packets; saturates at 255.

Behaviour:
- Reset (rst_n=0 at a clk_sys edge):
  - pos_x=X_MAX/2 (integer divide), pos_y=Y_MAX/2.
  - Buttons=0, pos_vld=0, err_cnt=0, stage-1 valid cleared.
  - An in-flight packet is discarded.
  - Reset overrides every other input.
- Status byte fields: bit3 = sync (must be 1); bit4 = X sign; bit5 = Y sign; bit6 = X overflow; bit7 = Y overflow.
- Stage 1, at the edge where rd_vld=1:
  - If bit3=0: drop the packet, err_cnt++ (saturating), no stage-2 activity.
  - Otherwise form the 9-bit signed dx = {bit4, X byte} and dy = {bit5, Y byte}.
  - Overflow on an axis: that delta is forced to +255 (sign=0) or −256 (sign=1).
  - Shift each delta left by SPEED_SHIFT.
  - If INVERT_Y=1, negate dy.
  - Register the deltas and button bits, and set s1_vld.
- Stage 2, at the edge where s1_vld=1:
  - sum = pos + delta, computed in signed POS_W+SPEED_SHIFT+2 bits.
  - Clamp: sum<0 gives 0; sum>MAX gives MAX; otherwise sum.
  - Write pos_x, pos_y and the buttons; pos_vld=1 for that one cycle.
- Latency: rd_vld at edge N gives updated outputs and pos_vld=1 after edge N+2.
- Throughput: one packet per cycle.
  - Only stage 2 writes pos, so back-to-back packets accumulate correctly with no hazard.
  - pos_vld may stay high on consecutive cycles.
- recentre:
  - At an edge with recentre=1: pos_x/pos_y load their centre values and buttons are unchanged.
  - If stage 2 fires on the same edge, centre wins for position; buttons still take the packet value and pos_vld=1.
  - recentre alone also pulses pos_vld.
  - The packet in stage 1 at that edge applies to the centred position on the next edge.
- rd_data is ignored whenever rd_vld=0.
- No backpressure: every rd_vld strobe is accepted.
- Outputs are registered, with no combinational path from input to output.

Test Plan:
- Reset, then check outputs idle → pos_x=319, pos_y=239, buttons 0, err_cnt 0, pos_vld 0.
- Packet 0x08_05_03 (defaults) → 2 cycles later pos_x=324, pos_y=236 (inverted), one pos_vld pulse.
- Packet 0x19_9C_00 (X sign, L pressed, dx=−100) issued 4 times back-to-back on consecutive cycles:
  - pos_vld high for 4 cycles.
  - pos_x goes 219, 119, 19, 0 (clamped).
  - btn_l=1.
- Packet with X overflow, 0x48_00_00, from pos_x=600 → pos_x=639 (clamp); repeat with SPEED_SHIFT=3 → still 639, no wrap.
- Packets 0x00_10_10 and 0x07_10_10 (bit3=0) → no pos_vld, position unchanged, err_cnt=2.
  - Then force 300 bad packets → err_cnt holds 255.
- recentre on the same edge as a stage-2 update of packet 0x0A_20_20 → pos=319/239, btn_r=1, single pos_vld.
  - Then rd_vld asserted with rst_n=0 on the same edge → packet discarded, outputs at reset values.

Source files
------------

// File: rtl/mouse_pos_tracker.sv
// ---------------------------------------------------------------------------
// mouse_pos_tracker
//
// Turns 3-byte PS/2 mouse packets into an absolute, clamped cursor position
// plus button state. Two register stages:
//   stage 1 : check the sync bit, build signed X/Y deltas (overflow
//             saturation, sensitivity shift, optional Y inversion)
//   stage 2 : add the deltas to the current position and clamp the result
//             to 0..X_MAX / 0..Y_MAX
// Packets with the sync bit clear are dropped and counted in err_cnt.
//
// Ports:
//   clk_sys   in   system clock
//   rst_n     in   synchronous active-low reset
//   rd_vld    in   one-cycle strobe, rd_data holds a complete packet
//   rd_data   in   [23:16] status, [15:8] X movement, [7:0] Y movement
//   recentre  in   one-cycle pulse, move the cursor to the screen centre
//   pos_x     out  current X, 0..X_MAX
//   pos_y     out  current Y, 0..Y_MAX
//   btn_l     out  left button   (status bit0)
//   btn_r     out  right button  (status bit1)
//   btn_m     out  middle button (status bit2)
//   pos_vld   out  one-cycle pulse, position/buttons were just written
//   err_cnt   out  dropped-packet count, saturates at 255
//
// Handshake: rd_vld is a pure valid strobe with no ready. Every cycle with
// rd_vld=1 delivers exactly one packet and it is always accepted; rd_data is
// don't-care whenever rd_vld=0. pos_vld is likewise a valid-only strobe to
// the consumers and may stay high on consecutive cycles.
// ---------------------------------------------------------------------------
module mouse_pos_tracker #(
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int POS_W       = 10,
    parameter int SPEED_SHIFT = 0,
    parameter int INVERT_Y    = 1
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             rd_vld,
    input  logic [23:0]      rd_data,
    input  logic             recentre,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             btn_l,
    output logic             btn_r,
    output logic             btn_m,
    output logic             pos_vld,
    output logic [7:0]       err_cnt
);

    // Delta: 9-bit PS/2 value, widened by the shift, plus one bit so that
    // negating the most negative value (-256 << SPEED_SHIFT) cannot wrap.
    localparam int D_W = 10 + SPEED_SHIFT;
    // Sum: wide enough for any position plus any delta without overflow.
    localparam int S_W = POS_W + SPEED_SHIFT + 2;

    localparam logic [POS_W-1:0]        X_CTR = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0]        Y_CTR = POS_W'(Y_MAX / 2);
    localparam logic signed [S_W-1:0]   X_LIM = S_W'(X_MAX);
    localparam logic signed [S_W-1:0]   Y_LIM = S_W'(Y_MAX);

    // Status byte fields
    logic st_sync, st_xsign, st_ysign, st_xovf, st_yovf;
    assign st_sync  = rd_data[19];
    assign st_xsign = rd_data[20];
    assign st_ysign = rd_data[21];
    assign st_xovf  = rd_data[22];
    assign st_yovf  = rd_data[23];

    // Overflowed axes saturate to the extreme of the 9-bit range in the
    // direction given by the sign bit.
    function automatic logic signed [D_W-1:0] make_delta(
        input logic       sign,
        input logic       ovf,
        input logic [7:0] mag,
        input logic       neg
    );
        logic signed [8:0]     raw;
        logic signed [D_W-1:0] ext;
        if (ovf) begin
            raw = sign ? 9'sh100 : 9'sh0FF;
        end else begin
            raw = $signed({sign, mag});
        end
        ext = {{(D_W-9){raw[8]}}, raw};
        ext = ext <<< SPEED_SHIFT;
        if (neg) begin
            ext = -ext;
        end
        return ext;
    endfunction

    function automatic logic [POS_W-1:0] clamp(
        input logic signed [S_W-1:0] s,
        input logic signed [S_W-1:0] lim
    );
        if (s < 0) begin
            return '0;
        end else if (s > lim) begin
            return lim[POS_W-1:0];
        end else begin
            return s[POS_W-1:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: decode
    // ------------------------------------------------------------------
    logic                  s1_vld;
    logic signed [D_W-1:0] s1_dx;
    logic signed [D_W-1:0] s1_dy;
    logic [2:0]            s1_btn;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_dx   <= '0;
            s1_dy   <= '0;
            s1_btn  <= '0;
            err_cnt <= '0;
        end else begin
            s1_vld <= 1'b0;
            if (rd_vld) begin
                if (!st_sync) begin
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end else begin
                    s1_vld <= 1'b1;
                    s1_dx  <= make_delta(st_xsign, st_xovf, rd_data[15:8], 1'b0);
                    s1_dy  <= make_delta(st_ysign, st_yovf, rd_data[7:0],
                                         (INVERT_Y != 0));
                    s1_btn <= rd_data[18:16];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate and clamp
    // ------------------------------------------------------------------
    logic signed [S_W-1:0] sum_x, sum_y;
    logic [POS_W-1:0]      nxt_x, nxt_y;

    always_comb begin
        sum_x = $signed({{(S_W-POS_W){1'b0}}, pos_x})
              + $signed({{(S_W-D_W){s1_dx[D_W-1]}}, s1_dx});
        sum_y = $signed({{(S_W-POS_W){1'b0}}, pos_y})
              + $signed({{(S_W-D_W){s1_dy[D_W-1]}}, s1_dy});
        nxt_x = clamp(sum_x, X_LIM);
        nxt_y = clamp(sum_y, Y_LIM);
    end

    logic [2:0] btn_q;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            pos_x   <= X_CTR;
            pos_y   <= Y_CTR;
            btn_q   <= '0;
            pos_vld <= 1'b0;
        end else begin
            pos_vld <= s1_vld | recentre;
            if (s1_vld) begin
                pos_x <= nxt_x;
                pos_y <= nxt_y;
                btn_q <= s1_btn;
            end
            // Centre wins over a coincident packet for position only; the
            // packet's buttons still land above.
            if (recentre) begin
                pos_x <= X_CTR;
                pos_y <= Y_CTR;
            end
        end
    end

    assign btn_l = btn_q[0];
    assign btn_r = btn_q[1];
    assign btn_m = btn_q[2];

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// ---------------------------------------------------------------------------
// tb_mouse_pos_tracker
//
// Two instances share the stimulus: u_dut0 with default parameters and
// u_dut1 with SPEED_SHIFT=3. A behavioural model computes each expected
// cursor update with integer arithmetic and queues it, stamped with the
// cycle at which pos_vld must appear; a negedge monitor pops and compares.
// A vector table, hand-written corner sequences and a random phase drive it.
// ---------------------------------------------------------------------------
module tb_mouse_pos_tracker;

    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;
    localparam int X_CTR = 319;
    localparam int Y_CTR = 239;
    localparam int EW    = 43;   // {cycle[19:0], btn[2:0], y[9:0], x[9:0]}

    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        rst_n;
    logic        rd_vld;
    logic [23:0] rd_data;
    logic        recentre;

    logic [9:0] pos_x0, pos_y0, pos_x1, pos_y1;
    logic       btn_l0, btn_r0, btn_m0, btn_l1, btn_r1, btn_m1;
    logic       pos_vld0, pos_vld1;
    logic [7:0] err_cnt0, err_cnt1;

    mouse_pos_tracker u_dut0 (
        .clk_sys(clk_sys), .rst_n(rst_n), .rd_vld(rd_vld), .rd_data(rd_data),
        .recentre(recentre), .pos_x(pos_x0), .pos_y(pos_y0),
        .btn_l(btn_l0), .btn_r(btn_r0), .btn_m(btn_m0),
        .pos_vld(pos_vld0), .err_cnt(err_cnt0)
    );

    mouse_pos_tracker #(.SPEED_SHIFT(3)) u_dut1 (
        .clk_sys(clk_sys), .rst_n(rst_n), .rd_vld(rd_vld), .rd_data(rd_data),
        .recentre(recentre), .pos_x(pos_x1), .pos_y(pos_y1),
        .btn_l(btn_l1), .btn_r(btn_r1), .btn_m(btn_m1),
        .pos_vld(pos_vld1), .err_cnt(err_cnt1)
    );

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int mx[2];
    int my[2];
    int mbtn;
    int merr;
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int axis_delta(input logic sign, input logic ovf,
                                      input logic [7:0] mag, input int sh);
        int d;
        if (ovf) d = sign ? -256 : 255;
        else     d = sign ? int'(mag) - 256 : int'(mag);
        return d * (1 << sh);
    endfunction

    task automatic model_push(input int at);
        exp_q0.push_back({20'(at), 3'(mbtn), 10'(my[0]), 10'(mx[0])});
        exp_q1.push_back({20'(at), 3'(mbtn), 10'(my[1]), 10'(mx[1])});
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mx[s] = X_CTR;
            my[s] = Y_CTR;
        end
        mbtn = 0;
        merr = 0;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_pkt(input logic [23:0] d);
        int sh;
        if (!d[19]) begin
            if (merr < 255) merr++;
            return;
        end
        mbtn = int'(d[18:16]);
        for (int s = 0; s < 2; s++) begin
            sh = (s == 0) ? 0 : 3;
            mx[s] = clampi(mx[s] + axis_delta(d[20], d[22], d[15:8], sh), X_MAX);
            // PS/2 up is screen-down inverted
            my[s] = clampi(my[s] - axis_delta(d[21], d[23], d[7:0], sh), Y_MAX);
        end
        model_push(cyc + 2);
    endtask

    task automatic model_recentre();
        for (int s = 0; s < 2; s++) begin
            mx[s] = X_CTR;
            my[s] = Y_CTR;
        end
        model_push(cyc + 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    int vld_cnt0 = 0;
    int seen_x0[$];

    task automatic mon_one(input int idx, input logic vld, input logic [9:0] x,
                           input logic [9:0] y, input logic [2:0] b);
        logic [EW-1:0] e;
        bit have;
        int at;
        have = (idx == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        e    = '0;
        at   = 0;
        if (have) begin
            e  = (idx == 0) ? exp_q0[0] : exp_q1[0];
            at = int'(e[42:23]);
        end
        if (vld) begin
            if (!have || at != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut%0d_pos_vld: got unexpected pulse at cycle %0d, next expected at %0d",
                         idx, cyc, have ? at : -1);
                if (have && at < cyc) begin
                    if (idx == 0) void'(exp_q0.pop_front());
                    else          void'(exp_q1.pop_front());
                end
            end else begin
                if (idx == 0) void'(exp_q0.pop_front());
                else          void'(exp_q1.pop_front());
                check($sformatf("dut%0d_pos_x", idx), int'(x), int'(e[9:0]));
                check($sformatf("dut%0d_pos_y", idx), int'(y), int'(e[19:10]));
                check($sformatf("dut%0d_btn", idx), int'(b), int'(e[22:20]));
            end
        end else if (have && at <= cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d_pos_vld: got no pulse, required one at cycle %0d", idx, at);
            if (idx == 0) void'(exp_q0.pop_front());
            else          void'(exp_q1.pop_front());
        end
    endtask

    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (pos_vld0) begin
                vld_cnt0++;
                seen_x0.push_back(int'(pos_x0));
            end
            mon_one(0, pos_vld0, pos_x0, pos_y0, {btn_m0, btn_r0, btn_l0});
            mon_one(1, pos_vld1, pos_x1, pos_y1, {btn_m1, btn_r1, btn_l1});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic vld, input logic [23:0] d, input logic rec);
        @(posedge clk_sys);
        #1;
        rd_vld   = vld;
        rd_data  = d;
        recentre = rec;
        if (rec) model_recentre();
        if (vld) model_pkt(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk_sys);
        #1;
        rst_n    = 1'b0;
        rd_vld   = 1'b0;
        recentre = 1'b0;
        model_reset();
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_outputs(input string tag, input int x, input int y,
                                 input int b, input int err);
        check({tag, "_x"}, int'(pos_x0), x);
        check({tag, "_y"}, int'(pos_y0), y);
        check({tag, "_btn"}, int'({btn_m0, btn_r0, btn_l0}), b);
        check({tag, "_err"}, int'(err_cnt0), err);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [23:0] data;
        logic        vld;
        int          x;
        int          y;
        int          btn;
        int          err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [23:0] d;
        int          r;
        bit          prev_pkt;
        int          v0;
        logic [EW-1:0] e;

        tbl[0]  = '{24'h08_05_03, 1'b1, 324, 236, 0, 0};
        tbl[1]  = '{24'h19_9C_00, 1'b1, 224, 236, 1, 0};
        tbl[2]  = '{24'h00_10_10, 1'b0, 224, 236, 1, 1};
        tbl[3]  = '{24'h07_10_10, 1'b0, 224, 236, 1, 2};
        tbl[4]  = '{24'h0A_20_20, 1'b1, 256, 204, 2, 2};
        tbl[5]  = '{24'h28_00_10, 1'b1, 256, 444, 0, 2};
        tbl[6]  = '{24'h08_00_7F, 1'b1, 256, 317, 0, 2};
        tbl[7]  = '{24'h88_00_00, 1'b1, 256,  62, 0, 2};
        tbl[8]  = '{24'h88_00_00, 1'b1, 256,   0, 0, 2};
        tbl[9]  = '{24'hA8_00_00, 1'b1, 256, 256, 0, 2};
        tbl[10] = '{24'hA8_00_00, 1'b1, 256, 479, 0, 2};
        tbl[11] = '{24'h0C_00_00, 1'b1, 256, 479, 4, 2};
        tbl[12] = '{24'h18_00_00, 1'b1,   0, 479, 0, 2};
        tbl[13] = '{24'h08_FF_00, 1'b1, 255, 479, 0, 2};

        rst_n    = 1'b0;
        rd_vld   = 1'b0;
        rd_data  = '0;
        recentre = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk_sys);
        check_outputs("reset", X_CTR, Y_CTR, 0, 0);
        check("reset_pos_vld", int'(pos_vld0), 0);
        check("reset_dut1_x", int'(pos_x1), X_CTR);
        check("reset_dut1_y", int'(pos_y1), Y_CTR);

        // Table: one packet at a time, checked two edges later
        for (int i = 0; i < 14; i++) begin
            step(1'b1, tbl[i].data, 1'b0);
            idle(2);
            @(negedge clk_sys);
            check($sformatf("tbl%0d_pos_vld", i), int'(pos_vld0), int'(tbl[i].vld));
            check_outputs($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].btn, tbl[i].err);
        end

        // Back-to-back packets accumulate, pos_vld high four cycles
        do_reset();
        seen_x0.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 24'h19_9C_00, 1'b0);
        idle(3);
        check("b2b_count", seen_x0.size(), 4);
        if (seen_x0.size() == 4) begin
            check("b2b_x0", seen_x0[0], 219);
            check("b2b_x1", seen_x0[1], 119);
            check("b2b_x2", seen_x0[2], 19);
            check("b2b_x3", seen_x0[3], 0);
        end
        check("b2b_btn_l", int'(btn_l0), 1);

        // X overflow near the right edge; shifted instance must not wrap
        do_reset();
        step(1'b1, 24'h48_00_00, 1'b0);
        step(1'b1, 24'h08_1A_00, 1'b0);
        idle(3);
        check("ovf_pre_x", int'(pos_x0), 600);
        step(1'b1, 24'h48_00_00, 1'b0);
        idle(3);
        check("ovf_x_dut0", int'(pos_x0), 639);
        check("ovf_x_dut1", int'(pos_x1), 639);
        step(1'b1, 24'h48_00_00, 1'b0);
        idle(3);
        check("ovf_again_x_dut1", int'(pos_x1), 639);

        // Malformed packets, then saturation of err_cnt
        do_reset();
        step(1'b1, 24'h00_10_10, 1'b0);
        step(1'b1, 24'h07_10_10, 1'b0);
        idle(3);
        check_outputs("bad2", X_CTR, Y_CTR, 0, 2);
        for (int i = 0; i < 300; i++) begin
            d = 24'($urandom);
            d[19] = 1'b0;
            step(1'b1, d, 1'b0);
        end
        idle(3);
        check("bad_sat_dut0", int'(err_cnt0), 255);
        check("bad_sat_dut1", int'(err_cnt1), 255);
        check("bad_sat_x", int'(pos_x0), X_CTR);

        // recentre alone: centre, buttons kept, one pulse
        do_reset();
        step(1'b1, 24'h09_10_00, 1'b0);
        idle(3);
        check("rc_pre_x", int'(pos_x0), 335);
        v0 = vld_cnt0;
        step(1'b0, 24'($urandom), 1'b1);
        idle(3);
        check("rc_alone_pulses", vld_cnt0 - v0, 1);
        check_outputs("rc_alone", X_CTR, Y_CTR, 1, 0);

        // recentre on the same edge as a stage-2 update
        step(1'b1, 24'h0A_20_20, 1'b0);
        @(posedge clk_sys);
        #1;
        rd_vld   = 1'b0;
        recentre = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mx[s] = X_CTR;
            my[s] = Y_CTR;
        end
        e = exp_q0.pop_back();
        exp_q0.push_back({e[42:20], 10'(Y_CTR), 10'(X_CTR)});
        e = exp_q1.pop_back();
        exp_q1.push_back({e[42:20], 10'(Y_CTR), 10'(X_CTR)});
        v0 = vld_cnt0;
        idle(3);
        check("rc_coinc_pulses", vld_cnt0 - v0, 1);
        check_outputs("rc_coinc", X_CTR, Y_CTR, 2, 0);

        // rd_vld on the reset edge is discarded
        step(1'b1, 24'h08_40_40, 1'b0);
        idle(3);
        @(posedge clk_sys);
        #1;
        rst_n   = 1'b0;
        rd_vld  = 1'b1;
        rd_data = 24'h0F_7F_7F;
        model_reset();
        @(posedge clk_sys);
        #1;
        rst_n  = 1'b1;
        rd_vld = 1'b0;
        v0 = vld_cnt0;
        idle(3);
        check("rst_vld_pulses", vld_cnt0 - v0, 0);
        check_outputs("rst_vld", X_CTR, Y_CTR, 0, 0);

        // Random traffic against the model
        do_reset();
        prev_pkt = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            d = 24'($urandom);
            if (r < 60) begin
                d[19] = 1'b1;
                step(1'b1, d, 1'b0);
                prev_pkt = 1'b1;
            end else if (r < 70) begin
                d[19] = 1'b0;
                step(1'b1, d, 1'b0);
                prev_pkt = 1'b0;
            end else if (r < 76 && !prev_pkt) begin
                step(1'b0, d, 1'b1);
                prev_pkt = 1'b0;
            end else begin
                step(1'b0, d, 1'b0);
                prev_pkt = 1'b0;
            end
        end
        idle(3);
        check("rnd_x_dut0", int'(pos_x0), mx[0]);
        check("rnd_y_dut0", int'(pos_y0), my[0]);
        check("rnd_x_dut1", int'(pos_x1), mx[1]);
        check("rnd_y_dut1", int'(pos_y1), my[1]);
        check("rnd_err_dut0", int'(err_cnt0), merr);
        check("rnd_err_dut1", int'(err_cnt1), merr);
        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
